trim_dco_model: RTL and testbench
=================================

# trim_dco_model

Behavioural digitally-controlled oscillator that closes the PLL loop in simulation and on FPGA. It consumes the 26-bit thermometer `trim` word driven by `pll_controller` and produces the `osc` square wave that the controller measures. Each active trim bit shortens the oscillator half-period by a fixed number of `clock` cycles. Trim updates are applied only at phase boundaries so the controller never sees a runt pulse.

## Interface
- BASE_HALF, 40: osc half-period in `clock` cycles at trim code 0 (range 2..255)
- STEP, 1: half-period reduction in cycles per active trim bit
- MIN_HALF, 2: floor on the half-period (≥1)
- clock  input  1  system clock; all logic is on the rising edge
- reset  input  1  asynchronous, active-low reset (0 = reset asserted)
- enable  input  1  run request; oscillation starts and stops only at defined boundaries
- trim  input  26  thermometer trim code, LSB-filled (bit 0 is the first to turn on)
- osc  output  1  generated oscillator output, registered
- osc_edge  output  1  one-cycle pulse in the cycle `osc` goes 0→1
- code  output  5  population count of the trim word latched at the last phase start (0..26)
- trim_err  output  1  sticky flag: a non-thermometer trim word was latched

## Operation
- Reset (reset=0, async): state=IDLE; osc=0, osc_edge=0, code=0, trim_err=0, counter=0.
- States: IDLE, HIGH, LOW.
- IDLE: osc=0. When enable=1, go to HIGH next cycle; latch trim, set osc=1, pulse osc_edge.
- Phase start (entering HIGH or LOW): latch trim; code=popcount(trim); counter=half-1; trim_err |= (trim not of the form 0…01…1). The all-zero word is valid.
- half = BASE_HALF − STEP·code, computed in 16-bit unsigned with a compare first; if BASE_HALF < STEP·code + MIN_HALF then half=MIN_HALF.
- HIGH/LOW: counter decrements each cycle. When counter=0, the phase ends.
  - HIGH end: go to LOW, osc=0.
  - LOW end: if enable=1, go to HIGH, osc=1, osc_edge=1. Otherwise go to IDLE.
- enable=0 during HIGH: the high phase completes, then the FSM goes to IDLE. No LOW phase is timed and osc stays 0.
- enable=0 during LOW: go to IDLE on the next cycle. osc is already 0, so no glitch occurs.
- trim changes mid-phase have no effect until the next phase start. code, trim_err and osc are unaffected.
- The popcount uses every bit, even for a non-thermometer word. trim_err only reports the malformed word.

## Timing
- osc is high for exactly `half` clock cycles and low for exactly `half` cycles. Period = 2·half, duty 50%.
- Latency from IDLE with enable=1 sampled to osc=1 is 1 cycle.
- A trim change sampled in cycle t takes effect at the first phase start after t. That can be up to `half` cycles later.
- code and trim_err update in the same cycle that osc toggles.
- osc_edge is high for one cycle only. It aligns with the osc 0→1 transition.
- Reset deasserting while enable=1: the first osc rise occurs 1 cycle after the first rising clock edge with reset=1.

## Test plan
- Defaults, trim=0, enable=1, 10 ns clock.
  - Expect osc period 80 cycles (800 ns), high 40 / low 40.
  - Expect code=0, trim_err=0, and one osc_edge per period.
- trim=26'h00000FF.
  - Expect code=8, half=32, period 64 cycles.
- trim=26'h3FFFFFF.
  - Expect code=26, half=14, period 28.
  - With STEP=2, expect the clamp to give half=2, period 4.
- trim=26'h0000005 (non-thermometer).
  - At the next phase start, expect trim_err=1, code=2, half=38.
  - trim_err stays 1 after trim returns to 26'h0000003.
- Change trim from 0 to 26'h00000FF 5 cycles into a HIGH phase.
  - The current high phase still lasts 40 cycles; the following low phase lasts 32.
- Drop enable mid-HIGH.
  - osc completes the 40-cycle high phase, then stays 0 in IDLE.
- Assert reset=0 mid-LOW.
  - osc, osc_edge, code and trim_err go to 0 immediately (asynchronously).
  - After release with enable=1, osc rises 1 cycle after the first clock edge.

Source files
------------

// File: rtl/trim_dco_model_if.sv
// Control and observation bundle between pll_controller (master) and the DCO model (slave).
// The master drives the run request and trim word and watches osc, code and trim_err.
interface trim_dco_model_if;
  logic        enable;
  logic [25:0] trim;
  logic        osc;
  logic        osc_edge;
  logic [4:0]  code;
  logic        trim_err;

  modport master (
    output enable, trim,
    input  osc, osc_edge, code, trim_err
  );

  modport slave (
    input  enable, trim,
    output osc, osc_edge, code, trim_err
  );
endinterface

// File: rtl/trim_dco_model.sv
// Behavioural trimmed DCO: osc half-period shrinks by STEP clocks per active trim bit.
// The trim word is latched only at phase starts, so the output never carries a runt pulse.
module trim_dco_model #(
  parameter int unsigned BASE_HALF = 40,
  parameter int unsigned STEP      = 1,
  parameter int unsigned MIN_HALF  = 2
) (
  input logic              clock,
  input logic              reset,
  trim_dco_model_if.slave  dco
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] HIGH = 2'd1;
  localparam logic [1:0] LOW  = 2'd2;

  localparam logic [15:0] BaseHalf = 16'(BASE_HALF);
  localparam logic [15:0] StepLen  = 16'(STEP);
  localparam logic [15:0] MinHalf  = 16'(MIN_HALF);

  logic [1:0]  state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        osc_q, osc_d;
  logic        edge_q, edge_d;
  logic [4:0]  code_q, code_d;
  logic        err_q, err_d;

  logic [4:0]  trim_pop;
  logic [25:0] trim_plus;
  logic        trim_bad;
  logic [15:0] step_prod;
  logic [15:0] half_len;
  logic [7:0]  cnt_load;
  logic        phase_start;

  // Trim decode for the word that would be latched at a phase start this cycle.
  always_comb begin
    trim_pop = '0;
    for (int i = 0; i < 26; i++) begin
      trim_pop = trim_pop + {4'd0, dco.trim[i]};
    end
    // A thermometer word plus one has no bit in common with itself; all-zero passes too.
    trim_plus = dco.trim + 26'd1;
    trim_bad  = |(dco.trim & trim_plus);
    step_prod = StepLen * {11'd0, trim_pop};
    if (BaseHalf < step_prod + MinHalf) begin
      half_len = MinHalf;
    end else begin
      half_len = BaseHalf - step_prod;
    end
    cnt_load = 8'(half_len - 16'd1);
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    osc_d       = osc_q;
    edge_d      = 1'b0;
    code_d      = code_q;
    err_d       = err_q;
    phase_start = 1'b0;
    case (state_q)
      IDLE: begin
        osc_d = 1'b0;
        if (dco.enable) begin
          state_d     = HIGH;
          osc_d       = 1'b1;
          edge_d      = 1'b1;
          phase_start = 1'b1;
        end
      end
      HIGH: begin
        if (cnt_q == 8'd0) begin
          osc_d = 1'b0;
          if (dco.enable) begin
            state_d     = LOW;
            phase_start = 1'b1;
          end else begin
            state_d = IDLE;
            cnt_d   = 8'd0;
          end
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      LOW: begin
        if (!dco.enable) begin
          state_d = IDLE;
          cnt_d   = 8'd0;
        end else if (cnt_q == 8'd0) begin
          state_d     = HIGH;
          osc_d       = 1'b1;
          edge_d      = 1'b1;
          phase_start = 1'b1;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      default: begin
        state_d = IDLE;
        osc_d   = 1'b0;
        cnt_d   = 8'd0;
      end
    endcase
    if (phase_start) begin
      code_d = trim_pop;
      cnt_d  = cnt_load;
      err_d  = err_q | trim_bad;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= 8'd0;
      osc_q   <= 1'b0;
      edge_q  <= 1'b0;
      code_q  <= 5'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      osc_q   <= osc_d;
      edge_q  <= edge_d;
      code_q  <= code_d;
      err_q   <= err_d;
    end
  end

  assign dco.osc      = osc_q;
  assign dco.osc_edge = edge_q;
  assign dco.code     = code_q;
  assign dco.trim_err = err_q;

endmodule

// File: tb/tb_trim_dco_model.sv
// Directed bench for trim_dco_model: phase widths, trim latching, sticky error, enable and reset.
module tb_trim_dco_model;
  logic clock;
  logic reset;
  int   total;
  int   bad;

  trim_dco_model_if dif ();
  trim_dco_model_if dif2 ();

  trim_dco_model u_dut (
    .clock (clock),
    .reset (reset),
    .dco   (dif.slave)
  );

  // Steep trim step so a full code hits the MIN_HALF floor.
  trim_dco_model #(
    .BASE_HALF (40),
    .STEP      (2),
    .MIN_HALF  (2)
  ) u_dut2 (
    .clock (clock),
    .reset (reset),
    .dco   (dif2.slave)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Counts ticks while osc holds lvl; stops on the first tick where it differs.
  task automatic count_run(input logic lvl, output int n);
    n = 0;
    while (dif.osc === lvl && n < 300) begin
      n++;
      tick();
    end
  endtask

  initial begin
    int          n0;
    int          n1;
    int          hits;
    logic [7:0]  pat2;

    total = 0;
    bad   = 0;
    reset = 1'b0;
    dif.enable  = 1'b0;
    dif.trim    = 26'h0;
    dif2.enable = 1'b1;
    dif2.trim   = 26'h3FFFFFF;

    #22;
    check("rst_osc", {31'd0, dif.osc}, 32'd0);
    check("rst_edge", {31'd0, dif.osc_edge}, 32'd0);
    check("rst_code", {27'd0, dif.code}, 32'd0);
    check("rst_err", {31'd0, dif.trim_err}, 32'd0);

    // Default trim: 40/40 and one edge per period.
    dif.enable = 1'b1;
    #1 reset = 1'b1;
    tick();
    check("first_rise_osc", {31'd0, dif.osc}, 32'd1);
    check("first_rise_edge", {31'd0, dif.osc_edge}, 32'd1);
    pat2 = '0;
    for (int i = 0; i < 8; i++) begin
      pat2[i] = dif2.osc;
      if (i == 0) check("clamp_code", {27'd0, dif2.code}, 32'd26);
      if (i == 1) check("edge_one_cycle", {31'd0, dif.osc_edge}, 32'd0);
      tick();
    end
    check("clamp_half2_pattern", {24'd0, pat2}, 32'h33);
    count_run(1'b1, n1);
    check("t0_high", n1 + 8, 32'd40);
    check("t0_code", {27'd0, dif.code}, 32'd0);
    check("t0_err", {31'd0, dif.trim_err}, 32'd0);
    count_run(1'b0, n1);
    check("t0_low", n1, 32'd40);
    check("t0_rise_edge", {31'd0, dif.osc_edge}, 32'd1);

    // trim=FF applied 5 cycles into HIGH: this high stays 40, next low is 32.
    n0 = 0;
    repeat (5) begin
      n0++;
      tick();
    end
    dif.trim = 26'h00000FF;
    check("midphase_code", {27'd0, dif.code}, 32'd0);
    count_run(1'b1, n1);
    check("midphase_high", n0 + n1, 32'd40);
    check("ff_code", {27'd0, dif.code}, 32'd8);
    count_run(1'b0, n1);
    check("ff_low", n1, 32'd32);
    count_run(1'b1, n1);
    check("ff_high", n1, 32'd32);

    // Full trim word: half 14.
    dif.trim = 26'h3FFFFFF;
    count_run(1'b0, n1);
    check("ff_low2", n1, 32'd32);
    check("full_code", {27'd0, dif.code}, 32'd26);
    count_run(1'b1, n1);
    check("full_high", n1, 32'd14);
    count_run(1'b0, n1);
    check("full_low", n1, 32'd14);

    // Non-thermometer word 5: code 2, half 38, sticky error.
    dif.trim = 26'h0000005;
    check("bad_err_before", {31'd0, dif.trim_err}, 32'd0);
    count_run(1'b1, n1);
    check("full_high2", n1, 32'd14);
    check("bad_err", {31'd0, dif.trim_err}, 32'd1);
    check("bad_code", {27'd0, dif.code}, 32'd2);
    dif.trim = 26'h0000003;
    count_run(1'b0, n1);
    check("bad_low", n1, 32'd38);
    check("sticky_err", {31'd0, dif.trim_err}, 32'd1);
    check("three_code", {27'd0, dif.code}, 32'd2);
    dif.trim = 26'h0;
    count_run(1'b1, n1);
    check("three_high", n1, 32'd38);
    check("zero_code", {27'd0, dif.code}, 32'd0);
    count_run(1'b0, n1);
    check("zero_low", n1, 32'd40);

    // Drop enable mid-HIGH: high completes, then idle.
    n0 = 0;
    repeat (5) begin
      n0++;
      tick();
    end
    dif.enable = 1'b0;
    count_run(1'b1, n1);
    check("drop_high", n0 + n1, 32'd40);
    hits = 0;
    repeat (100) begin
      if (dif.osc !== 1'b0 || dif.osc_edge !== 1'b0) hits++;
      tick();
    end
    check("idle_quiet", hits, 32'd0);

    // Restart with trim=FF, then async reset mid-LOW.
    dif.trim   = 26'h00000FF;
    dif.enable = 1'b1;
    n0 = 0;
    while (dif.osc_edge !== 1'b1 && n0 < 10) begin
      n0++;
      tick();
    end
    check("restart_latency", n0, 32'd1);
    check("restart_code", {27'd0, dif.code}, 32'd8);
    count_run(1'b1, n1);
    check("restart_high", n1, 32'd32);
    repeat (3) tick();
    #2 reset = 1'b0;
    #1;
    check("async_osc", {31'd0, dif.osc}, 32'd0);
    check("async_edge", {31'd0, dif.osc_edge}, 32'd0);
    check("async_code", {27'd0, dif.code}, 32'd0);
    check("async_err", {31'd0, dif.trim_err}, 32'd0);
    #2 reset = 1'b1;
    check("release_pre_osc", {31'd0, dif.osc}, 32'd0);
    tick();
    check("release_osc", {31'd0, dif.osc}, 32'd1);
    check("release_edge", {31'd0, dif.osc_edge}, 32'd1);
    check("release_code", {27'd0, dif.code}, 32'd8);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
